// File: rtl/serial_word_comparator.sv
// serial_word_comparator
//   Streaming magnitude comparator. Operands A and B arrive DIGIT_W bits per
//   accepted beat, WORD_DIGITS beats per word, most-significant digit first
//   (MSB_FIRST=1) or least-significant digit first (MSB_FIRST=0). One
//   registered less/equal/greater result is produced per completed word.
//
//   Optional build macro SERIAL_CMP_SIGNED_EN: when defined, the operands are
//   compared as two's complement by inverting the MSB of the sign digit.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   valid        beat carries a digit pair
//   first        (with valid) beat is digit 0 of a word
//   a, b         current digits of operands A and B
//   res_valid    one-cycle pulse: new result on the result outputs
//   a_less_b     registered result, held until the next word completes
//   a_eq_b       registered result, held until the next word completes
//   a_greater_b  registered result, held until the next word completes
//   frame_err    one-cycle pulse: a partial word was discarded
module serial_word_comparator #(
  parameter int unsigned DIGIT_W     = 1,
  parameter int unsigned WORD_DIGITS = 8,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               first,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               res_valid,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b,
  output logic               frame_err
);

  localparam int unsigned CNT_W = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_DIGITS - 1);
`ifdef SERIAL_CMP_SIGNED_EN
  localparam logic [CNT_W-1:0] SIGN_IDX = MSB_FIRST ? CNT_W'(0) : LAST_IDX;
`endif

  typedef enum logic [1:0] {
    ST_EQ,
    ST_LESS,
    ST_GREATER
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               res_valid_q, res_valid_d;
  logic               lt_q, lt_d;
  logic               eq_q, eq_d;
  logic               gt_q, gt_d;
  logic               frame_err_q, frame_err_d;

  logic               word_start;
  logic [CNT_W-1:0]   idx;
  state_e             base_state;
  state_e             decision;
  logic [DIGIT_W-1:0] a_cmp, b_cmp;
  logic               d_lt, d_gt;

  // A beat opens a new word either at counter 0 or when first is asserted;
  // in both cases it is digit 0 and is combined with ST_EQ, so a re-framed
  // word never inherits state from the discarded partial word.
  always_comb begin
    word_start = (cnt_q == '0) || first;
    idx        = word_start ? '0 : cnt_q;
    base_state = word_start ? ST_EQ : state_q;
  end

  always_comb begin
    a_cmp = a;
    b_cmp = b;
`ifdef SERIAL_CMP_SIGNED_EN
    // Flipping the sign bit maps two's complement order onto unsigned order.
    if (idx == SIGN_IDX) begin
      a_cmp[DIGIT_W-1] = ~a[DIGIT_W-1];
      b_cmp[DIGIT_W-1] = ~b[DIGIT_W-1];
    end
`endif
    d_lt = (a_cmp < b_cmp);
    d_gt = (a_cmp > b_cmp);
  end

  // MSB first: first difference is final. LSB first: latest difference wins.
  always_comb begin
    decision = base_state;
    if (MSB_FIRST) begin
      if (base_state == ST_EQ) begin
        if (d_lt)      decision = ST_LESS;
        else if (d_gt) decision = ST_GREATER;
      end
    end else begin
      if (d_lt)      decision = ST_LESS;
      else if (d_gt) decision = ST_GREATER;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_valid_d = 1'b0;
    frame_err_d = 1'b0;
    lt_d        = lt_q;
    eq_d        = eq_q;
    gt_d        = gt_q;
    if (valid) begin
      if (first && (cnt_q != '0)) frame_err_d = 1'b1;
      if (idx == LAST_IDX) begin
        res_valid_d = 1'b1;
        lt_d        = (decision == ST_LESS);
        eq_d        = (decision == ST_EQ);
        gt_d        = (decision == ST_GREATER);
        cnt_d       = '0;
        state_d     = ST_EQ;
      end else begin
        cnt_d   = idx + CNT_W'(1);
        state_d = decision;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EQ;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      gt_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      frame_err_q <= frame_err_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      gt_q        <= gt_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign a_less_b    = lt_q;
  assign a_eq_b      = eq_q;
  assign a_greater_b = gt_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
module tb_serial_word_comparator;

  logic clk;
  logic rst;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  // m: 1-bit digits, 8 digits, MSB first
  logic m_valid, m_first, m_a, m_b;
  logic m_rv, m_lt, m_eq, m_gt, m_fe;
  // l: 1-bit digits, 8 digits, LSB first
  logic l_valid, l_first, l_a, l_b;
  logic l_rv, l_lt, l_eq, l_gt, l_fe;
  // h: 4-bit digits, 2 digits, MSB first
  logic       h_valid, h_first;
  logic [3:0] h_a, h_b;
  logic       h_rv, h_lt, h_eq, h_gt, h_fe;

  int m_fe_cnt = 0;
  int l_fe_cnt = 0;
  int h_fe_cnt = 0;

  typedef struct {
    logic [2:0] res;   // {lt, eq, gt}
    int         due;
  } exp_t;

  exp_t qm[$];
  exp_t ql[$];
  exp_t qh[$];
  exp_t em, el, eh;

  serial_word_comparator #(.DIGIT_W(1), .WORD_DIGITS(8), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst(rst), .valid(m_valid), .first(m_first), .a(m_a), .b(m_b),
    .res_valid(m_rv), .a_less_b(m_lt), .a_eq_b(m_eq), .a_greater_b(m_gt),
    .frame_err(m_fe)
  );

  serial_word_comparator #(.DIGIT_W(1), .WORD_DIGITS(8), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst(rst), .valid(l_valid), .first(l_first), .a(l_a), .b(l_b),
    .res_valid(l_rv), .a_less_b(l_lt), .a_eq_b(l_eq), .a_greater_b(l_gt),
    .frame_err(l_fe)
  );

  serial_word_comparator #(.DIGIT_W(4), .WORD_DIGITS(2), .MSB_FIRST(1'b1)) u_h (
    .clk(clk), .rst(rst), .valid(h_valid), .first(h_first), .a(h_a), .b(h_b),
    .res_valid(h_rv), .a_less_b(h_lt), .a_eq_b(h_eq), .a_greater_b(h_gt),
    .frame_err(h_fe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Whole-word reference compare, {lt, eq, gt}
  function automatic logic [2:0] ref_cmp(input logic [7:0] x, input logic [7:0] y);
    longint sx = longint'(x);
    longint sy = longint'(y);
`ifdef SERIAL_CMP_SIGNED_EN
    if (x[7]) sx = sx - 256;
    if (y[7]) sy = sy - 256;
`endif
    if (sx < sy)       return 3'b100;
    else if (sx == sy) return 3'b010;
    else               return 3'b001;
  endfunction

  // Scoreboard: each res_valid pops the oldest expected word result
  always @(negedge clk) begin
    if (m_fe) m_fe_cnt++;
    if (l_fe) l_fe_cnt++;
    if (h_fe) h_fe_cnt++;
    if (m_rv) begin
      checks++;
      if (qm.size() == 0) begin
        failures++;
        $display("FAIL m_result unexpected res_valid got=%b", {m_lt, m_eq, m_gt});
      end else begin
        em = qm.pop_front();
        if ({m_lt, m_eq, m_gt} !== em.res || cyc != em.due) begin
          failures++;
          $display("FAIL m_result got=%b exp=%b cycle=%0d due=%0d",
                   {m_lt, m_eq, m_gt}, em.res, cyc, em.due);
        end
      end
    end
    if (l_rv) begin
      checks++;
      if (ql.size() == 0) begin
        failures++;
        $display("FAIL l_result unexpected res_valid got=%b", {l_lt, l_eq, l_gt});
      end else begin
        el = ql.pop_front();
        if ({l_lt, l_eq, l_gt} !== el.res || cyc != el.due) begin
          failures++;
          $display("FAIL l_result got=%b exp=%b cycle=%0d due=%0d",
                   {l_lt, l_eq, l_gt}, el.res, cyc, el.due);
        end
      end
    end
    if (h_rv) begin
      checks++;
      if (qh.size() == 0) begin
        failures++;
        $display("FAIL h_result unexpected res_valid got=%b", {h_lt, h_eq, h_gt});
      end else begin
        eh = qh.pop_front();
        if ({h_lt, h_eq, h_gt} !== eh.res || cyc != eh.due) begin
          failures++;
          $display("FAIL h_result got=%b exp=%b cycle=%0d due=%0d",
                   {h_lt, h_eq, h_gt}, eh.res, cyc, eh.due);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      m_valid = 1'b0; m_first = 1'b0;
      l_valid = 1'b0; l_first = 1'b0;
      h_valid = 1'b0; h_first = 1'b0;
    end
  endtask

  task automatic m_beat(input logic v, input logic f, input logic da, input logic db);
    @(negedge clk);
    m_valid = v; m_first = f; m_a = da; m_b = db;
  endtask

  task automatic m_word(input logic [7:0] x, input logic [7:0] y);
    for (int i = 7; i >= 0; i--) begin
      m_beat(1'b1, (i == 7), x[i], y[i]);
      if (i == 0) qm.push_back('{res: ref_cmp(x, y), due: cyc + 1});
    end
  endtask

  task automatic l_word(input logic [7:0] x, input logic [7:0] y);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      l_valid = 1'b1; l_first = (i == 0); l_a = x[i]; l_b = y[i];
      if (i == 7) ql.push_back('{res: ref_cmp(x, y), due: cyc + 1});
    end
  endtask

  task automatic h_word(input logic [7:0] x, input logic [7:0] y, input int gap);
    @(negedge clk);
    h_valid = 1'b1; h_first = 1'b1; h_a = x[7:4]; h_b = y[7:4];
    if (gap > 0) idle(gap);
    @(negedge clk);
    h_valid = 1'b1; h_first = 1'b0; h_a = x[3:0]; h_b = y[3:0];
    qh.push_back('{res: ref_cmp(x, y), due: cyc + 1});
    if (gap > 0) idle(gap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({m_rv, m_lt, m_eq, m_gt, m_fe} !== 5'b0) begin
      failures++;
      $display("FAIL reset_m got=%b exp=00000", {m_rv, m_lt, m_eq, m_gt, m_fe});
    end
    checks++;
    if ({l_rv, l_lt, l_eq, l_gt, l_fe} !== 5'b0) begin
      failures++;
      $display("FAIL reset_l got=%b exp=00000", {l_rv, l_lt, l_eq, l_gt, l_fe});
    end
    checks++;
    if ({h_rv, h_lt, h_eq, h_gt, h_fe} !== 5'b0) begin
      failures++;
      $display("FAIL reset_h got=%b exp=00000", {h_rv, h_lt, h_eq, h_gt, h_fe});
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_msb_first();
    m_word(8'hA5, 8'hA3);
    m_word(8'h12, 8'h92);
    idle(3);
    checks++;
    if (qm.size() != 0) begin
      failures++;
      $display("FAIL msb_first_pending got=%0d exp=0", qm.size());
    end
    checks++;
    if ({m_lt, m_eq, m_gt} !== ref_cmp(8'h12, 8'h92)) begin
      failures++;
      $display("FAIL msb_first_hold got=%b exp=%b", {m_lt, m_eq, m_gt}, ref_cmp(8'h12, 8'h92));
    end
  endtask

  task automatic test_lsb_first();
    l_word(8'h01, 8'h80);
    idle(3);
    checks++;
    if (ql.size() != 0) begin
      failures++;
      $display("FAIL lsb_first_pending got=%0d exp=0", ql.size());
    end
  endtask

  task automatic test_gaps();
    h_word(8'h3C, 8'h3C, 3);
    idle(2);
    checks++;
    if (qh.size() != 0) begin
      failures++;
      $display("FAIL gaps_pending got=%0d exp=0", qh.size());
    end
  endtask

  task automatic test_back_to_back();
    h_word(8'h10, 8'h0F, 0);
    h_word(8'h00, 8'h00, 0);
    h_word(8'h0F, 8'hF0, 0);
    idle(3);
    checks++;
    if (qh.size() != 0) begin
      failures++;
      $display("FAIL back_to_back_pending got=%0d exp=0", qh.size());
    end
  endtask

  task automatic test_frame_err();
    int fe0 = m_fe_cnt;
    for (int j = 0; j < 3; j++) m_beat(1'b1, (j == 0), 1'b1, 1'b0);
    m_word(8'h05, 8'h07);
    idle(3);
    checks++;
    if (m_fe_cnt - fe0 != 1) begin
      failures++;
      $display("FAIL frame_err_count got=%0d exp=1", m_fe_cnt - fe0);
    end
    checks++;
    if (qm.size() != 0) begin
      failures++;
      $display("FAIL frame_err_pending got=%0d exp=0", qm.size());
    end
  endtask

  task automatic test_reset_mid_word();
    int fe0 = m_fe_cnt;
    for (int j = 0; j < 5; j++) m_beat(1'b1, (j == 0), 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; m_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_rv, m_lt, m_eq, m_gt} !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid_during got=%b exp=0000", {m_rv, m_lt, m_eq, m_gt});
    end
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    checks++;
    if ({m_rv, m_lt, m_eq, m_gt} !== 4'b0) begin
      failures++;
      $display("FAIL reset_mid_after got=%b exp=0000", {m_rv, m_lt, m_eq, m_gt});
    end
    m_word(8'h00, 8'h00);
    idle(3);
    checks++;
    if ({m_lt, m_eq, m_gt} !== 3'b010 || qm.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_word got=%b exp=010 pending=%0d", {m_lt, m_eq, m_gt}, qm.size());
    end
    checks++;
    if (m_fe_cnt != fe0) begin
      failures++;
      $display("FAIL reset_mid_frame_err got=%0d exp=0", m_fe_cnt - fe0);
    end
  endtask

  task automatic test_signed();
    m_word(8'h80, 8'h01);
    idle(3);
    checks++;
    if ({m_lt, m_eq, m_gt} !== ref_cmp(8'h80, 8'h01) || qm.size() != 0) begin
      failures++;
      $display("FAIL signed_cmp got=%b exp=%b pending=%0d",
               {m_lt, m_eq, m_gt}, ref_cmp(8'h80, 8'h01), qm.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    m_valid = 1'b0; m_first = 1'b0; m_a = 1'b0; m_b = 1'b0;
    l_valid = 1'b0; l_first = 1'b0; l_a = 1'b0; l_b = 1'b0;
    h_valid = 1'b0; h_first = 1'b0; h_a = '0;   h_b = '0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_gaps();
    test_back_to_back();
    test_frame_err();
    test_reset_mid_word();
    test_signed();
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_comparator.md
Name: serial_word_comparator

Overview:
- Streaming magnitude comparator for two operands that arrive serially, DIGIT_W bits per accepted beat, over WORD_DIGITS beats per word.
- Digit order is selectable at elaboration: most-significant digit first or least-significant digit first.
- A registered less/equal/greater result is produced once per completed word.
- Sits after deserialising front-ends (serial links, bit-serial ALUs) wherever a full word compare is needed without parallel buffering.

Parameters:
- DIGIT_W, 1: bits of a and b consumed per accepted beat; must be >= 1.
- WORD_DIGITS, 8: digits per word; must be >= 1. The word width is DIGIT_W*WORD_DIGITS.
- MSB_FIRST, 1: 1 means the first digit of a word is the most significant; 0 means it is the least significant.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- valid, input, 1: the beat carries a digit pair; beats with valid=0 are ignored entirely.
- first, input, 1: qualified by valid; marks digit 0 of a word.
- a, input, DIGIT_W: current digit of operand A.
- b, input, DIGIT_W: current digit of operand B.
- res_valid, output, 1: one-cycle pulse; a new result is on the result outputs.
- a_less_b, output, 1: registered result, held until the next word completes.
- a_eq_b, output, 1: registered result, held until the next word completes.
- a_greater_b, output, 1: registered result, held until the next word completes.
- frame_err, output, 1: one-cycle pulse; a partial word was discarded.

Behaviour:
- Reset: digit counter = 0, FSM = ST_EQ, res_valid = 0, frame_err = 0, and a_less_b = a_eq_b = a_greater_b = 0.
- FSM states:
  - ST_EQ: all digits so far are equal.
  - ST_LESS: the accumulated decision is A < B.
  - ST_GREATER: the accumulated decision is A > B.
- Digit compare: unsigned DIGIT_W-bit compare of a against b, giving d_lt, d_eq or d_gt.
- MSB_FIRST=1 (decision is sticky):
  - From ST_EQ, d_lt goes to ST_LESS and d_gt goes to ST_GREATER.
  - ST_LESS and ST_GREATER hold until the end of the word.
- MSB_FIRST=0 (latest decision wins):
  - Any d_lt goes to ST_LESS and any d_gt goes to ST_GREATER.
  - d_eq keeps the current state.
- Counter: increments on every accepted beat; wraps to 0 after digit WORD_DIGITS-1.
- Word start: a beat with counter = 0 starts a word whether or not first is high. The beat's digit is combined with ST_EQ, not with leftover state.
- first with counter != 0:
  - The partial word is discarded.
  - The beat is taken as digit 0 of a new word (counter becomes 1 and the FSM is restarted from this digit).
  - frame_err pulses in the next cycle.
  - The result outputs and res_valid are unaffected.
- Last digit (counter = WORD_DIGITS-1):
  - The final decision combines the FSM state with the current digit compare using the same rule.
  - The decision is registered onto the result outputs, and exactly one result output is 1.
  - res_valid = 1 for one cycle. Latency is 1 clock after the last digit beat.
  - The counter returns to 0 and the FSM to ST_EQ.
- Back-to-back words: supported with no bubble. A last-digit beat followed immediately by a digit-0 beat is legal and loses no throughput.
- WORD_DIGITS=1: every accepted beat is a full word, and res_valid follows every valid beat by 1 clock. first never produces frame_err in this configuration.
- Idle cycles (valid=0) inside a word: the counter and FSM hold.
- Reset mid-word: the partial word is dropped silently, no frame_err, and the previous result is cleared to all-zero.
- With valid=0, the values of a, b and first are don't-care.

Optional Feature:
- Macro: SERIAL_CMP_SIGNED_EN.
- Defined: operands are compared as two's complement. The most significant bit of the sign digit has its value inverted before the digit compare. The sign digit is digit 0 when MSB_FIRST=1 and digit WORD_DIGITS-1 when MSB_FIRST=0. All other digits compare unsigned.
- Not defined: a pure unsigned compare, and no extra logic is generated.

Test Plan:
1. DIGIT_W=1, WORD_DIGITS=8, MSB_FIRST=1. Send a=0xA5, b=0xA3 MSB first; bits first differ at bit 2. Required: a_greater_b=1 and res_valid for exactly one cycle, 1 clock after the 8th beat. Then send a=0x12, b=0x92. Required: a_less_b=1.
2. Same sizes, MSB_FIRST=0. Send a=0x01, b=0x80 LSB first; the LSB goes to A first and the MSB goes to B last. Required: a_less_b=1, showing that the later difference overrides the earlier one.
3. DIGIT_W=4, WORD_DIGITS=2. Send a=0x3C, b=0x3C with valid=0 gaps of 3 cycles between beats. Required: a_eq_b=1. Next, three back-to-back words (0x10 vs 0x0F, 0x00 vs 0x00, 0x0F vs 0xF0). Required: three consecutive res_valid pulses with results gt, eq, lt.
4. DIGIT_W=1, WORD_DIGITS=8. Send 3 beats, then first=1, then a full 8-digit word a=0x05, b=0x07. Required: frame_err pulses once; the single res_valid that follows shows a_less_b=1.
5. Assert rst after 5 digits of a word, then send a complete word a=b=0x00. Required: all result outputs are 0 and res_valid=0 during and after the reset, then a_eq_b=1 after the word. No frame_err.
6. Macro defined, DIGIT_W=1, WORD_DIGITS=8, MSB_FIRST=1. Send a=0x80, b=0x01. Required: a_less_b=1. With the macro undefined, the same stimulus requires a_greater_b=1.
